// File: rtl/slot_arb.sv
// Round-robin allocator/releaser between NREQ requesters and a shared slot manager.
// Tracks per-requester held-slot counts and enforces a per-requester quota.
module slot_arb #(
   parameter int unsigned NREQ  = 4,
   parameter int unsigned DEPTH = 1024,
   parameter int unsigned QUOTA = 512,
   localparam int unsigned AW = $clog2(DEPTH),
   localparam int unsigned CW = $clog2(DEPTH) + 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NREQ-1:0]    alloc_req,
   output logic [NREQ-1:0]    alloc_gnt,
   output logic [AW-1:0]      alloc_addr,
   input  logic [NREQ-1:0]    rel_req,
   input  logic [NREQ*AW-1:0] rel_addr,
   output logic [NREQ-1:0]    rel_ack,
   output logic               slot_set,
   input  logic [AW-1:0]      slot_nxt_addr,
   input  logic               slot_full,
   output logic               slot_clr,
   output logic [AW-1:0]      slot_clr_addr,
   output logic [NREQ*CW-1:0] owned_cnt,
   output logic               rel_err
);

   localparam int unsigned PW = $clog2(NREQ);

   logic [PW-1:0]   ap_q, ap_d, rp_q, rp_d;
   logic [CW-1:0]   cnt_q [NREQ];
   logic [CW-1:0]   cnt_d [NREQ];
   logic            rel_err_q, rel_err_d;
   logic [NREQ-1:0] alloc_elig;
   logic [AW-1:0]   rel_addr_a [NREQ];
   logic            a_found, r_found;
   logic [PW-1:0]   ia, ir, r_idx;
   logic [PW:0]     sa, sr;

   always_comb begin
      for (int i = 0; i < NREQ; i++) begin
         alloc_elig[i] = alloc_req[i] && !slot_full && (cnt_q[i] < CW'(QUOTA));
         rel_addr_a[i] = rel_addr[i*AW +: AW];
         owned_cnt[i*CW +: CW] = cnt_q[i];
      end
   end

   // Two independent round-robin searches starting at ap_q / rp_q.
   always_comb begin
      alloc_gnt = '0;
      rel_ack   = '0;
      ap_d      = ap_q;
      rp_d      = rp_q;
      a_found   = 1'b0;
      r_found   = 1'b0;
      r_idx     = '0;
      ia        = '0;
      ir        = '0;
      sa        = '0;
      sr        = '0;
      for (int k = 0; k < NREQ; k++) begin
         sa = {1'b0, ap_q} + (PW+1)'(k);
         if (sa >= (PW+1)'(NREQ)) sa = sa - (PW+1)'(NREQ);
         ia = sa[PW-1:0];
         sr = {1'b0, rp_q} + (PW+1)'(k);
         if (sr >= (PW+1)'(NREQ)) sr = sr - (PW+1)'(NREQ);
         ir = sr[PW-1:0];
         if (!a_found && alloc_elig[ia]) begin
            a_found       = 1'b1;
            alloc_gnt[ia] = 1'b1;
            ap_d          = (ia == PW'(NREQ - 1)) ? '0 : ia + 1'b1;
         end
         if (!r_found && rel_req[ir]) begin
            r_found     = 1'b1;
            rel_ack[ir] = 1'b1;
            r_idx       = ir;
            rp_d        = (ir == PW'(NREQ - 1)) ? '0 : ir + 1'b1;
         end
      end
      if (rst) begin
         alloc_gnt = '0;
         rel_ack   = '0;
         r_found   = 1'b0;
      end
   end

   assign slot_set      = |alloc_gnt;
   assign alloc_addr    = slot_nxt_addr;
   assign slot_clr_addr = rel_addr_a[r_idx];
   // A release from an empty requester is acked but never returned to the manager.
   assign slot_clr      = r_found && (cnt_q[r_idx] != '0);
   assign rel_err_d     = rel_err_q | (r_found && (cnt_q[r_idx] == '0));
   assign rel_err       = rel_err_q;

   always_comb begin
      for (int i = 0; i < NREQ; i++) begin
         cnt_d[i] = cnt_q[i] + CW'(alloc_gnt[i])
                    - CW'(rel_ack[i] && (cnt_q[i] != '0));
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ap_q      <= '0;
         rp_q      <= '0;
         rel_err_q <= 1'b0;
         for (int i = 0; i < NREQ; i++) cnt_q[i] <= '0;
      end else begin
         ap_q      <= ap_d;
         rp_q      <= rp_d;
         rel_err_q <= rel_err_d;
         for (int i = 0; i < NREQ; i++) cnt_q[i] <= cnt_d[i];
      end
   end

endmodule

// File: tb/tb_slot_arb.sv
// Directed self-checking bench for slot_arb (NREQ=4, DEPTH=16, QUOTA=4).
module tb_slot_arb;

   localparam int unsigned NREQ  = 4;
   localparam int unsigned DEPTH = 16;
   localparam int unsigned QUOTA = 4;
   localparam int unsigned AW    = 4;
   localparam int unsigned CW    = 5;

   logic               clk = 1'b0;
   logic               rst;
   logic [NREQ-1:0]    alloc_req;
   logic [NREQ-1:0]    alloc_gnt;
   logic [AW-1:0]      alloc_addr;
   logic [NREQ-1:0]    rel_req;
   logic [NREQ*AW-1:0] rel_addr;
   logic [NREQ-1:0]    rel_ack;
   logic               slot_set;
   logic [AW-1:0]      slot_nxt_addr;
   logic               slot_full;
   logic               slot_clr;
   logic [AW-1:0]      slot_clr_addr;
   logic [NREQ*CW-1:0] owned_cnt;
   logic               rel_err;

   int n_checks = 0;
   int n_errors = 0;

   slot_arb #(.NREQ(NREQ), .DEPTH(DEPTH), .QUOTA(QUOTA)) dut (
      .clk           (clk),
      .rst           (rst),
      .alloc_req     (alloc_req),
      .alloc_gnt     (alloc_gnt),
      .alloc_addr    (alloc_addr),
      .rel_req       (rel_req),
      .rel_addr      (rel_addr),
      .rel_ack       (rel_ack),
      .slot_set      (slot_set),
      .slot_nxt_addr (slot_nxt_addr),
      .slot_full     (slot_full),
      .slot_clr      (slot_clr),
      .slot_clr_addr (slot_clr_addr),
      .owned_cnt     (owned_cnt),
      .rel_err       (rel_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] cnt(input int i);
      logic [CW-1:0] c;
      c = owned_cnt[i*CW +: CW];
      return {27'b0, c};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   int exp_g [5] = '{0, 1, 2, 3, 0};

   initial begin
      rst           = 1'b1;
      alloc_req     = '1;
      rel_req       = '1;
      rel_addr      = {4'hD, 4'hC, 4'hB, 4'hA};
      slot_nxt_addr = '0;
      slot_full     = 1'b0;

      // Outputs quiet during reset regardless of requests.
      @(negedge clk);
      check("rst_gnt", alloc_gnt, 0);
      check("rst_ack", rel_ack, 0);
      check("rst_set", slot_set, 0);
      check("rst_clr", slot_clr, 0);
      check("rst_cnt", owned_cnt, 0);
      check("rst_err", rel_err, 0);
      @(posedge clk);
      #1;
      rst       = 1'b0;
      alloc_req = '0;
      rel_req   = '0;

      // Round-robin over all four requesters.
      alloc_req = 4'b1111;
      for (int c = 0; c < 5; c++) begin
         slot_nxt_addr = AW'(5 + c);
         @(negedge clk);
         check("rr_gnt", alloc_gnt, 32'(1) << exp_g[c]);
         check("rr_addr", alloc_addr, 5 + c);
         check("rr_set", slot_set, 1);
         tick();
      end
      alloc_req = '0;
      check("rr_cnt0", cnt(0), 2);
      check("rr_cnt1", cnt(1), 1);
      check("rr_cnt2", cnt(2), 1);
      check("rr_cnt3", cnt(3), 1);

      // slot_full blocks allocation while a release still proceeds.
      slot_full = 1'b1;
      alloc_req = 4'b1111;
      rel_req   = 4'b0001;
      @(negedge clk);
      check("full_gnt", alloc_gnt, 0);
      check("full_set", slot_set, 0);
      check("full_ack", rel_ack, 4'b0001);
      check("full_clr", slot_clr, 1);
      check("full_clr_addr", slot_clr_addr, 4'hA);
      tick();
      check("full_cnt0_a", cnt(0), 1);
      @(negedge clk);
      check("full_ack2", rel_ack, 4'b0001);
      tick();
      check("full_cnt0_b", cnt(0), 0);
      slot_full = 1'b0;
      alloc_req = '0;
      rel_req   = '0;

      // Drain requester 3, then release once more from empty.
      rel_req = 4'b1000;
      @(negedge clk);
      check("r3_clr", slot_clr, 1);
      check("r3_clr_addr", slot_clr_addr, 4'hD);
      tick();
      check("r3_cnt", cnt(3), 0);
      check("r3_err0", rel_err, 0);
      @(negedge clk);
      check("empty_ack", rel_ack, 4'b1000);
      check("empty_clr", slot_clr, 0);
      tick();
      check("empty_cnt", cnt(3), 0);
      check("empty_err", rel_err, 1);
      rel_req = '0;
      tick();
      check("err_sticky", rel_err, 1);

      // Requester 2 builds up to 3 slots, then allocs and releases together.
      alloc_req     = 4'b0100;
      slot_nxt_addr = 4'h3;
      tick();
      tick();
      check("r2_cnt3", cnt(2), 3);
      rel_req = 4'b0100;
      @(negedge clk);
      check("same_gnt", alloc_gnt, 4'b0100);
      check("same_ack", rel_ack, 4'b0100);
      check("same_set", slot_set, 1);
      check("same_clr", slot_clr, 1);
      check("same_clr_addr", slot_clr_addr, 4'hC);
      tick();
      check("same_cnt", cnt(2), 3);
      rel_req = '0;

      // Quota: requester 2 reaches 4 and is then skipped.
      tick();
      check("q_cnt", cnt(2), 4);
      @(negedge clk);
      check("q_block", alloc_gnt, 0);
      tick();
      alloc_req = 4'b0110;
      @(negedge clk);
      check("q_other", alloc_gnt, 4'b0010);
      tick();
      alloc_req = 4'b0111;
      @(negedge clk);
      check("q_skip", alloc_gnt, 4'b0001);
      tick();
      check("q_cnt1", cnt(1), 2);
      check("q_cnt0", cnt(0), 1);

      // Mid-stream reset clears everything; pointers restart at 0.
      alloc_req = 4'b1111;
      rel_req   = 4'b1111;
      rst       = 1'b1;
      @(negedge clk);
      check("mrst_gnt", alloc_gnt, 0);
      check("mrst_ack", rel_ack, 0);
      check("mrst_clr", slot_clr, 0);
      check("mrst_cnt", owned_cnt, 0);
      check("mrst_err", rel_err, 0);
      tick();
      rst     = 1'b0;
      rel_req = '0;
      @(negedge clk);
      check("post_gnt", alloc_gnt, 4'b0001);
      tick();
      check("post_cnt0", cnt(0), 1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
